// File: rtl/result_display_pkg.sv
// Shared definitions for the result display: seven-segment codes, converter
// states, scan digit positions and the double-dabble nibble adjust.
package result_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_SIGN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
    function automatic logic [11:0] bcd_add3(input logic [11:0] bcd);
        logic [11:0] res;
        res = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential signed binary to sign-magnitude BCD converter (double dabble).
// A start in any state (re)enters LOAD; valid pulses only on an uninterrupted COMMIT.
module bin2bcd_seq
    import result_display_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic [11:0]       bcd,
    output logic              sign,
    output logic              valid,
    output logic              busy
);

    localparam int ITER_W = $clog2(DATA_W);

    conv_state_t       state_r;
    conv_state_t       next_s;
    logic [DATA_W-1:0] mag_r;
    logic [11:0]       bcd_r;
    logic              sign_r;
    logic [ITER_W-1:0] iter_r;
    logic [DATA_W:0]   ext_s;
    logic [DATA_W:0]   abs_s;
    logic [11:0]       adj_s;

    // One extra bit so the most negative input yields its true magnitude.
    assign ext_s = {value[DATA_W-1], value};
    assign abs_s = value[DATA_W-1] ? (~ext_s + {{DATA_W{1'b0}}, 1'b1}) : ext_s;
    assign adj_s = bcd_add3(bcd_r);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a request always wins and restarts from LOAD.
    always_comb begin
        next_s = state_r;
        if (start) begin
            next_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE:   next_s = ST_IDLE;
                ST_LOAD:   next_s = ST_SHIFT;
                ST_SHIFT:  next_s = (iter_r == ITER_W'(DATA_W - 1)) ? ST_COMMIT : ST_SHIFT;
                ST_COMMIT: next_s = ST_IDLE;
                default:   next_s = ST_IDLE;
            endcase
        end
    end

    // Working registers: load magnitude/sign, then shift-and-adjust.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_r  <= '0;
            bcd_r  <= 12'd0;
            sign_r <= 1'b0;
            iter_r <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    sign_r <= value[DATA_W-1];
                    mag_r  <= abs_s[DATA_W-1:0];
                    bcd_r  <= 12'd0;
                    iter_r <= '0;
                end
                ST_SHIFT: begin
                    bcd_r  <= {adj_s[10:0], mag_r[DATA_W-1]};
                    mag_r  <= {mag_r[DATA_W-2:0], 1'b0};
                    iter_r <= iter_r + ITER_W'(1);
                end
                default: begin
                    iter_r <= iter_r;
                end
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy  = (state_r != ST_IDLE);
        valid = (state_r == ST_COMMIT) && !start;
        bcd   = bcd_r;
        sign  = sign_r;
    end

endmodule

// File: rtl/result_display.sv
// Latches two signed results, converts the selected one to BCD and scans it
// onto a 4-digit active-low seven-segment display; a button toggles A/B.
module result_display
    import result_display_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] result_a,
    input  logic signed [DATA_W-1:0] result_b,
    input  logic                     done,
    input  logic                     btn_sel,
    output logic [6:0]               seg,
    output logic [3:0]               an,
    output logic                     dp,
    output logic                     sel,
    output logic                     busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic              btn_sync1_r;
    logic              btn_sync2_r;
    logic              btn_prev_r;
    logic              btn_rise_s;
    logic [DATA_W-1:0] lat_a_r;
    logic [DATA_W-1:0] lat_b_r;
    logic              sel_r;
    logic              start_s;
    logic [DATA_W-1:0] conv_value_s;
    logic [11:0]       conv_bcd_s;
    logic              conv_sign_s;
    logic              conv_valid_s;
    logic [11:0]       disp_bcd_r;
    logic              disp_sign_r;
    logic [CNT_W-1:0]  refresh_cnt_r;
    logic [1:0]        scan_idx_r;
    logic [6:0]        digit_seg_s;

    // Two-flop synchroniser plus previous-state flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync1_r <= 1'b0;
            btn_sync2_r <= 1'b0;
            btn_prev_r  <= 1'b0;
        end else begin
            btn_sync1_r <= btn_sel;
            btn_sync2_r <= btn_sync1_r;
            btn_prev_r  <= btn_sync2_r;
        end
    end

    assign btn_rise_s   = btn_sync2_r & ~btn_prev_r;
    assign start_s      = done | btn_rise_s;
    assign conv_value_s = sel_r ? lat_b_r : lat_a_r;
    assign sel          = sel_r;

    // Result capture and A/B selection toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_a_r <= '0;
            lat_b_r <= '0;
            sel_r   <= 1'b0;
        end else begin
            if (done) begin
                lat_a_r <= result_a;
                lat_b_r <= result_b;
            end
            if (btn_rise_s) begin
                sel_r <= ~sel_r;
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .value (conv_value_s),
        .bcd   (conv_bcd_s),
        .sign  (conv_sign_s),
        .valid (conv_valid_s),
        .busy  (busy)
    );

    // Display registers only change on a complete conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_bcd_r  <= 12'd0;
            disp_sign_r <= 1'b0;
        end else if (conv_valid_s) begin
            disp_bcd_r  <= conv_bcd_s;
            disp_sign_r <= conv_sign_s;
        end
    end

    // Refresh prescaler and digit scan index.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            scan_idx_r    <= DIG_ONES;
        end else if (refresh_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_r <= '0;
            scan_idx_r    <= scan_idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // Digit content with leading-zero blanking.
    always_comb begin
        digit_seg_s = SEG_BLANK;
        case (scan_idx_r)
            DIG_ONES:  digit_seg_s = seg_encode(disp_bcd_r[3:0]);
            DIG_TENS:  digit_seg_s = ((disp_bcd_r[11:8] == 4'd0) && (disp_bcd_r[7:4] == 4'd0))
                                     ? SEG_BLANK : seg_encode(disp_bcd_r[7:4]);
            DIG_HUNDS: digit_seg_s = (disp_bcd_r[11:8] == 4'd0) ? SEG_BLANK : seg_encode(disp_bcd_r[11:8]);
            DIG_SIGN:  digit_seg_s = disp_sign_r ? SEG_MINUS : SEG_BLANK;
            default:   digit_seg_s = SEG_BLANK;
        endcase
    end

    // Registered display drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= digit_seg_s;
            an  <= ~(4'b0001 << scan_idx_r);
            dp  <= ~((scan_idx_r == DIG_ONES) & sel_r);
        end
    end

endmodule
